demux_router: RTL

//   Inverse of the datapath N-input select muxes: one producer word is routed to
//   one of NUM_OUT consumer channels, chosen by an ADDR_BITS-wide address.

---
 rtl/demux_router_pkg.sv | 12 +
 rtl/demux_slot.sv | 27 ++
 rtl/demux_router.sv | 64 ++++++
 3 files changed

// File: rtl/demux_router_pkg.sv
// Shared defaults for the demux router: data width, address width and the
// channel-count derivation used by the top level.
package demux_router_pkg;

  localparam int DEMUX_WIDTH     = 32;
  localparam int DEMUX_ADDR_BITS = 5;

  function automatic int num_out(input int addr_bits);
    return 1 << addr_bits;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single router channel.
// A load wins over a pop, so a same-cycle refill keeps the slot full.
module demux_slot #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [width-1:0] data_in,
  input  logic             pop,
  output logic             valid,
  output logic [width-1:0] data_out
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      if (load)     valid <= 1'b1;
      else if (pop) valid <= 1'b0;
      // data is left untouched on a pop so the last word stays visible
      if (load) data_out <= data_in;
    end
  end

endmodule

// File: rtl/demux_router.sv
// Routes one producer word to one of NUM_OUT channels by address; each channel
// is a one-entry valid/ready slot, with a registered count of full channels.
module demux_router
  import demux_router_pkg::*;
#(
  parameter int width     = DEMUX_WIDTH,
  parameter int addr_bits = DEMUX_ADDR_BITS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [addr_bits-1:0]           in_addr,
  input  logic [width-1:0]               in_data,
  output logic [num_out(addr_bits)-1:0]  out_valid,
  input  logic [num_out(addr_bits)-1:0]  out_ready,
  output logic [num_out(addr_bits)*width-1:0] out_data,
  output logic [addr_bits:0]             occupancy
);

  localparam int NUM_OUT = num_out(addr_bits);
  localparam int CW      = addr_bits + 1;

  logic               push;
  logic               push_new;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] pop;
  logic [CW-1:0]      drained;

  // No path from in_valid: ready depends only on the addressed slot.
  assign in_ready = !out_valid[in_addr] || out_ready[in_addr];
  assign push     = in_valid && in_ready;
  assign push_new = push && !out_valid[in_addr];
  assign load     = push ? ({{(NUM_OUT-1){1'b0}}, 1'b1} << in_addr) : '0;
  assign pop      = out_valid & out_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_slot #(.width(width)) u_slot (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load[k]),
        .data_in  (in_data),
        .pop      (pop[k]),
        .valid    (out_valid[k]),
        .data_out (out_data[k*width +: width])
      );
    end
  endgenerate

  // Pops whose slot is refilled the same cycle do not change the count.
  always_comb begin
    drained = '0;
    for (int i = 0; i < NUM_OUT; i++)
      drained = drained + CW'(pop[i] && !load[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occupancy <= '0;
    else          occupancy <= occupancy + CW'(push_new) - drained;
  end

endmodule
